// File: rtl/phyreg_free_list_if.sv
// Rename/commit <-> physical register free list connection.
// Handshake: a rename slot is served in a cycle iff its req and its gnt are both high
// in that cycle; a stalled slot keeps req high; prd is meaningful only while gnt is high.
interface phyreg_free_list_if #(
  parameter int REG_SIZE_WIDTH = 6
);
  logic                      alloc_req_first_i;
  logic                      alloc_req_second_i;
  logic                      alloc_gnt_first_o;
  logic                      alloc_gnt_second_o;
  logic [REG_SIZE_WIDTH-1:0] alloc_prd_first_o;
  logic [REG_SIZE_WIDTH-1:0] alloc_prd_second_o;
  logic                      commit_alloc_first_i;
  logic                      commit_alloc_second_i;
  logic                      rel_valid_first_i;
  logic                      rel_valid_second_i;
  logic [REG_SIZE_WIDTH-1:0] rel_prd_first_i;
  logic [REG_SIZE_WIDTH-1:0] rel_prd_second_i;
  logic                      flush_i;
  logic [REG_SIZE_WIDTH-1:0] free_count_o;
  logic                      empty_o;
  logic                      overflow_err_o;

  modport master (
    output alloc_req_first_i, alloc_req_second_i,
    output commit_alloc_first_i, commit_alloc_second_i,
    output rel_valid_first_i, rel_valid_second_i, rel_prd_first_i, rel_prd_second_i,
    output flush_i,
    input  alloc_gnt_first_o, alloc_gnt_second_o, alloc_prd_first_o, alloc_prd_second_o,
    input  free_count_o, empty_o, overflow_err_o
  );

  modport slave (
    input  alloc_req_first_i, alloc_req_second_i,
    input  commit_alloc_first_i, commit_alloc_second_i,
    input  rel_valid_first_i, rel_valid_second_i, rel_prd_first_i, rel_prd_second_i,
    input  flush_i,
    output alloc_gnt_first_o, alloc_gnt_second_o, alloc_prd_first_o, alloc_prd_second_o,
    output free_count_o, empty_o, overflow_err_o
  );
endinterface

// File: rtl/phyreg_free_list.sv
// Circular free list of physical register indices: dual allocate, dual release,
// and flush recovery to the committed head pointer.
module phyreg_free_list #(
  parameter int REG_SIZE       = 64,
  parameter int REG_SIZE_WIDTH = 6,
  parameter int ARCH_REG_NUM   = 32,
  parameter int FL_DEPTH       = 32
) (
  input logic clk,
  input logic rst,
  phyreg_free_list_if.slave fl
);
  localparam int IDX_W = $clog2(FL_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  // First register not backing an architectural register after reset.
  localparam int FIRST_FREE = (REG_SIZE - FL_DEPTH > ARCH_REG_NUM) ? (REG_SIZE - FL_DEPTH) : ARCH_REG_NUM;

  logic [REG_SIZE_WIDTH-1:0] entry [FL_DEPTH];
  logic [PTR_W-1:0] head, commit_head, tail;
  logic [PTR_W-1:0] count, room, alloc_n, rel_n, rel_req_n;
  logic [PTR_W-1:0] head_next, commit_head_next, tail_next;
  logic [IDX_W-1:0] rd_idx_second, wr_idx_second;
  logic             gnt_first, gnt_second;
  logic             rel_q_first, rel_q_second, wr_ok_first, wr_ok_second;
  logic [REG_SIZE_WIDTH-1:0] wr_data_first;
  logic             overflow_err;

  assign count = tail - head;
  assign room  = PTR_W'(FL_DEPTH) - count;

  // Grants see only the pre-edge count; same-cycle releases are not bypassed.
  assign gnt_first  = fl.alloc_req_first_i && (count >= PTR_W'(1)) && !fl.flush_i && !rst;
  assign gnt_second = fl.alloc_req_second_i && !fl.flush_i && !rst &&
                      (fl.alloc_req_first_i ? (count >= PTR_W'(2)) : (count >= PTR_W'(1)));

  assign rd_idx_second = head[IDX_W-1:0] + IDX_W'(gnt_first);
  assign alloc_n       = PTR_W'(gnt_first) + PTR_W'(gnt_second);

  // Releases of P0 never qualify; qualifying ones are packed toward tail.
  assign rel_q_first   = fl.rel_valid_first_i  && (fl.rel_prd_first_i  != '0);
  assign rel_q_second  = fl.rel_valid_second_i && (fl.rel_prd_second_i != '0);
  assign rel_req_n     = PTR_W'(rel_q_first) + PTR_W'(rel_q_second);
  assign wr_ok_first   = (rel_q_first || rel_q_second) && (room >= PTR_W'(1));
  assign wr_ok_second  = rel_q_first && rel_q_second && (room >= PTR_W'(2));
  assign wr_data_first = rel_q_first ? fl.rel_prd_first_i : fl.rel_prd_second_i;
  assign wr_idx_second = tail[IDX_W-1:0] + IDX_W'(1);
  assign rel_n         = PTR_W'(wr_ok_first) + PTR_W'(wr_ok_second);

  assign commit_head_next = commit_head + PTR_W'(fl.commit_alloc_first_i) + PTR_W'(fl.commit_alloc_second_i);
  assign head_next        = fl.flush_i ? commit_head_next : (head + alloc_n);
  assign tail_next        = tail + rel_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FL_DEPTH; k++) begin
        entry[k] <= REG_SIZE_WIDTH'(FIRST_FREE + k);
      end
      head         <= '0;
      commit_head  <= '0;
      tail         <= PTR_W'(FL_DEPTH);
      overflow_err <= 1'b0;
    end else begin
      if (wr_ok_first) begin
        entry[tail[IDX_W-1:0]] <= wr_data_first;
      end
      if (wr_ok_second) begin
        entry[wr_idx_second] <= fl.rel_prd_second_i;
      end
      head        <= head_next;
      commit_head <= commit_head_next;
      tail        <= tail_next;
      if (rel_n != rel_req_n) begin
        overflow_err <= 1'b1;
      end
    end
  end

  assign fl.alloc_gnt_first_o  = gnt_first;
  assign fl.alloc_gnt_second_o = gnt_second;
  assign fl.alloc_prd_first_o  = entry[head[IDX_W-1:0]];
  assign fl.alloc_prd_second_o = entry[rd_idx_second];
  assign fl.free_count_o       = REG_SIZE_WIDTH'(count);
  assign fl.empty_o            = (count == '0);
  assign fl.overflow_err_o     = overflow_err;
endmodule

// File: doc/phyreg_free_list.md
Name: phyreg_free_list

Overview:
- Allocator for the physical register file.
- Holds the indices of unmapped physical registers in a circular FIFO.
- Hands up to two destination registers per cycle to the rename stage.
- Takes back up to two stale registers per cycle from commit.
- Restores speculative allocations on a pipeline flush using a committed head pointer.
- P0 is hard-wired zero and is never allocated or freed.

Parameters:
- REG_SIZE, 64, number of physical registers.
- REG_SIZE_WIDTH, 6, index width; equals log2(REG_SIZE).
- ARCH_REG_NUM, 32, architectural registers (x0..x31).
- FL_DEPTH, 32, free-list capacity; equals REG_SIZE-ARCH_REG_NUM; must be a power of 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- alloc_req_first_i  in  1  rename slot 0 needs a destination.
- alloc_req_second_i  in  1  rename slot 1 needs a destination.
- alloc_gnt_first_o  out  1  slot 0 allocation granted.
- alloc_gnt_second_o  out  1  slot 1 allocation granted.
- alloc_prd_first_o  out  REG_SIZE_WIDTH  register given to slot 0.
- alloc_prd_second_o  out  REG_SIZE_WIDTH  register given to slot 1.
- commit_alloc_first_i  in  1  committing instr 0 had allocated a prd.
- commit_alloc_second_i  in  1  committing instr 1 had allocated a prd.
- rel_valid_first_i  in  1  free rel_prd_first_i.
- rel_valid_second_i  in  1  free rel_prd_second_i.
- rel_prd_first_i  in  REG_SIZE_WIDTH  stale prd from commit slot 0.
- rel_prd_second_i  in  REG_SIZE_WIDTH  stale prd from commit slot 1.
- flush_i  in  1  squash all uncommitted allocations.
- free_count_o  out  REG_SIZE_WIDTH  number of free entries (0..FL_DEPTH).
- empty_o  out  1  free_count_o==0.
- overflow_err_o  out  1  sticky: a release arrived while the list was full.

Behaviour:
- Storage:
  - FL_DEPTH entries of REG_SIZE_WIDTH bits.
  - Pointers head, commit_head and tail, each log2(FL_DEPTH)+1 bits wide; the MSB is the wrap bit.
  - count = tail-head, modulo 2^(log2(FL_DEPTH)+1).
- Reset (asynchronous):
  - entry[k] = ARCH_REG_NUM+k, so the list holds P32..P63.
  - head = commit_head = 0; tail = FL_DEPTH with wrap bit 1 and index 0, giving count=32.
  - overflow_err_o = 0.
  - Architectural regs x1..x31 are implicitly mapped to P1..P31.
- Grant (combinational, from pre-edge count only; no same-cycle bypass of releases):
  - gnt_first = req_first & count>=1 & !flush_i.
  - gnt_second = req_second & !flush_i & (req_first ? count>=2 : count>=1).
  - A slot that requests but is not granted must stall; it gets no partial service.
- Allocation data:
  - prd_first = entry[head].
  - prd_second = entry[head+gnt_first].
  - Outputs are valid only when the matching grant is high.
- Head update: on the clock edge, head += gnt_first+gnt_second.
- Commit: commit_head += commit_alloc_first_i + commit_alloc_second_i.
- Release:
  - Valid releases whose prd is nonzero are compacted.
  - The first qualifying release is written at tail, the second at tail+1.
  - tail advances by the number of qualifying releases.
  - A release of P0 is dropped silently.
- Overflow:
  - A release that would push count above FL_DEPTH is dropped and sets overflow_err_o.
  - overflow_err_o clears only on rst.
- Flush:
  - head <= commit_head_next, i.e. commit_head including any same-cycle commit increments.
  - Grants are forced to 0.
  - Releases and commits in the same cycle are still applied.
- Simultaneous alloc, release and commit in one cycle: all pointer updates apply independently.
- count never goes negative, because grants are limited by count.
- free_count_o and empty_o are combinational from the registered pointers.
- Wrap-around is handled by the index bits; the MSB distinguishes full from empty.
- Reset mid-operation: everything returns to the reset state in the same cycle rst asserts; grants are 0 while rst is high.

Test Plan:
- Reset check:
  - Release rst -> free_count_o=32, empty_o=0.
  - Dual request -> gnt both 1, prd_first=32, prd_second=33.
  - Next cycle free_count_o=30.
- Drain and stall:
  - 16 dual allocs -> empty_o=1.
  - 17th request -> both grants 0, free_count_o stays 0.
- Single remaining entry with count=1:
  - req_first=req_second=1 -> gnt_first=1, gnt_second=0.
  - req_first=0, req_second=1 -> gnt_second=1 and prd_second=entry[head].
- Flush recovery:
  - Allocate 6, commit 2 (commit_alloc both 1 in one cycle), then flush_i -> head returns to commit_head.
  - free_count_o=30.
  - Next allocation returns P34.
- Release and wrap:
  - Drain list, release P5 and P0 in the same cycle -> only P5 written, free_count_o=1.
  - Cycle 40 allocs/releases through -> tail wraps, returned indices match FIFO order.
- Overflow and async reset:
  - Release at count=32 -> entry not written, overflow_err_o=1.
  - Assert rst between clock edges -> outputs return to reset values immediately.
